event_readout_sequencer: RTL

Event readout engine that answers the read submission issued once every unmasked input channel has finished writing an event. On `read_submit` it walks the 16 per-channel event FIFOs in ascending channel order and serialises one framed event onto the 16-bit SFP transmit stream. When the frame is done it pulses per-channel request clears, so the channels can begin the next event. It sits between the channel buffers and the SFP TX framer.

---
 rtl/readout_pkg.sv | 40 ++++
 rtl/next_channel_finder.sv | 26 ++
 rtl/event_readout_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/readout_pkg.sv
// Shared state encoding, marker nibbles and word builders for the event readout path.
// Build option READOUT_CHECKSUM_EN adds a CHKSUM state for the trailing XOR word.
// Channel count and counter widths are fixed by the 16-channel front end.
package readout_pkg;

  localparam int CH_NUM = 16;
  localparam int CH_W   = 4;
  localparam int WORD_W = 16;
  localparam int CNT_W  = 12;

  localparam logic [3:0] HDR_MARK = 4'hA;
  localparam logic [3:0] CH_MARK  = 4'hC;
  localparam logic [3:0] TRL_MARK = 4'hE;

  // State names the section of the word most recently loaded into the output register
  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    CH_HDR,
    CH_DATA,
    TRAILER,
`ifdef READOUT_CHECKSUM_EN
    CHKSUM,
`endif
    DONE
  } state_t;

  function automatic logic [WORD_W-1:0] hdr_word(input logic [CNT_W-1:0] evt);
    return {HDR_MARK, evt};
  endfunction

  function automatic logic [WORD_W-1:0] ch_hdr_word(input logic [CH_W-1:0] ch);
    return {CH_MARK, 8'h00, ch};
  endfunction

  function automatic logic [WORD_W-1:0] trl_word(input logic [CNT_W-1:0] words);
    return {TRL_MARK, words};
  endfunction

endpackage

// File: rtl/next_channel_finder.sv
// Purpose: lowest set bit of the active mask above the current channel (or from 0).
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle by the sequencer.
module next_channel_finder
  import readout_pkg::*;
(
  input  logic [CH_NUM-1:0] mask,
  input  logic [CH_W-1:0]   cur,
  input  logic              from_start,
  output logic [CH_W-1:0]   ch,
  output logic              none
);

  // Scan downward so the lowest qualifying index is the last one written
  always_comb begin
    ch   = '0;
    none = 1'b1;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (i > int'(cur)))) begin
        ch   = CH_W'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/event_readout_sequencer.sv
// Purpose: walk unmasked channel FIFOs and serialise one framed event; optional READOUT_CHECKSUM_EN appends an XOR word.
// Latency: header valid the cycle after read_submit, then one word per cycle with ready high.
// Backpressure: registered output slot loads only when empty or accepted; stalled words are held and nothing is popped.
module event_readout_sequencer
  import readout_pkg::*;
#(
  parameter int                WORDS_PER_CH = 64,
  parameter int                MAX_WAIT     = 1000,
  parameter logic [WORD_W-1:0] PAD_WORD     = 16'hDEAD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_submit,
  input  logic               live_rising,
  input  logic [CH_NUM-1:0]  input_mask,
  input  logic [CH_NUM-1:0]  ch_empty,
  input  logic [WORD_W-1:0]  ch_data,
  output logic [CH_W-1:0]    ch_sel,
  output logic               ch_rd_en,
  output logic [WORD_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH_NUM-1:0]  clear_request,
  output logic               busy,
  output logic               overlap_err,
  output logic               underrun_err,
  output logic [CNT_W-1:0]   event_cnt
);

  localparam int                WAIT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0]  WORD_LIM = CNT_W'(WORDS_PER_CH);

  state_t              state, state_n;
  logic [CH_NUM-1:0]   act_mask;
  logic [CNT_W-1:0]    word_cnt;
  logic [CNT_W-1:0]    frame_words;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                slot_free;
  logic                load;
  logic                accept;
  logic                advance;
  logic                cnt_inc;
  logic                wait_inc;
  logic                pad;
  logic [WORD_W-1:0]   load_word;
  logic [CH_W-1:0]     sel_n;
  logic [CH_W-1:0]     nxt_ch;
  logic                nxt_none;
  logic                from_start;

`ifdef READOUT_CHECKSUM_EN
  logic [WORD_W-1:0]   csum;
`endif

  assign slot_free  = !out_valid || out_ready;
  assign busy       = (state != IDLE);
  assign from_start = (state == HEADER);

  next_channel_finder u_find (
    .mask       (act_mask),
    .cur        (ch_sel),
    .from_start (from_start),
    .ch         (nxt_ch),
    .none       (nxt_none)
  );

  // Next-state, output-slot load selection and FIFO pop decision
  always_comb begin
    state_n       = state;
    load          = 1'b0;
    load_word     = '0;
    accept        = 1'b0;
    advance       = 1'b0;
    cnt_inc       = 1'b0;
    wait_inc      = 1'b0;
    pad           = 1'b0;
    ch_rd_en      = 1'b0;
    sel_n         = ch_sel;
    clear_request = '0;
    case (state)
      IDLE: begin
        // The slot is always empty here: DONE is reached only after the last handshake
        if (read_submit) begin
          accept    = 1'b1;
          load      = 1'b1;
          load_word = hdr_word(event_cnt);
          state_n   = HEADER;
        end
      end
      HEADER: advance = slot_free;
      CH_HDR, CH_DATA: begin
        if (slot_free) begin
          if (word_cnt == WORD_LIM) begin
            advance = 1'b1;
          end else if (!ch_empty[ch_sel]) begin
            load      = 1'b1;
            load_word = ch_data;
            ch_rd_en  = 1'b1;
            cnt_inc   = 1'b1;
            state_n   = CH_DATA;
          end else if (wait_cnt == WAIT_LIM) begin
            // Give up on this word: pad it, do not pop, keep the frame length fixed
            load      = 1'b1;
            load_word = PAD_WORD;
            pad       = 1'b1;
            cnt_inc   = 1'b1;
            state_n   = CH_DATA;
          end else begin
            wait_inc = 1'b1;
          end
        end
      end
`ifdef READOUT_CHECKSUM_EN
      TRAILER: begin
        if (slot_free) begin
          load      = 1'b1;
          load_word = csum;
          state_n   = CHKSUM;
        end
      end
      CHKSUM: begin
        if (out_valid && out_ready) state_n = DONE;
      end
`else
      TRAILER: begin
        if (out_valid && out_ready) state_n = DONE;
      end
`endif
      DONE: begin
        clear_request = act_mask;
        state_n       = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Shared hand-off: open the next active channel block or close with the trailer
    if (advance) begin
      load = 1'b1;
      if (!nxt_none) begin
        load_word = ch_hdr_word(nxt_ch);
        sel_n     = nxt_ch;
        state_n   = CH_HDR;
      end else begin
        load_word = trl_word(frame_words);
        state_n   = TRAILER;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Output register, channel pointer and per-frame counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      ch_sel      <= '0;
      act_mask    <= '0;
      word_cnt    <= '0;
      frame_words <= '0;
      wait_cnt    <= '0;
    end else begin
      if (load) begin
        out_data  <= load_word;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      ch_sel <= sel_n;
      if (accept) act_mask <= ~input_mask;
      if (advance)      word_cnt <= '0;
      else if (cnt_inc) word_cnt <= word_cnt + 12'd1;
      if (accept) frame_words <= 12'd1;
      else if (load && (state_n == CH_HDR || state_n == CH_DATA)) frame_words <= frame_words + 12'd1;
      // Every loaded word restarts the empty-FIFO patience window
      if (load)          wait_cnt <= '0;
      else if (wait_inc) wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

`ifdef READOUT_CHECKSUM_EN
  // Running XOR of every word loaded since the header, trailer included
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         csum <= '0;
    else if (accept) csum <= load_word;
    else if (load)   csum <= csum ^ load_word;
  end
`endif

  // Event counter and sticky errors; live_rising wins over a same-cycle set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_cnt    <= '0;
      overlap_err  <= 1'b0;
      underrun_err <= 1'b0;
    end else begin
      if (state == DONE) event_cnt <= event_cnt + 12'd1;
      if (live_rising) begin
        overlap_err  <= 1'b0;
        underrun_err <= 1'b0;
      end else begin
        if (read_submit && busy) overlap_err <= 1'b1;
        if (pad)                 underrun_err <= 1'b1;
      end
    end
  end

endmodule
